// File: rtl/glitc_intercom_align_pkg.sv
// Shared intercom alignment types: FSM state encoding, default training word, counter widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package glitc_intercom_align_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        WAIT   = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } align_state_t;

    // Aligned training word; its four rotations are all distinct, so a
    // mismatch always means the word boundary is off.
    localparam logic [3:0] TRAIN_WORD_DEFAULT = 4'b0111;

    localparam int MATCH_W = 8;  // consecutive-match counter, MATCH_COUNT up to 255
    localparam int WAIT_W  = 8;  // post-bitslip settle counter, SLIP_WAIT up to 255
    localparam int SLIP_W  = 4;  // bitslip pulses per attempt, saturates at 15

endpackage

// File: rtl/glitc_intercom_align.sv
// Intercom word aligner: hunts for TRAIN_PATTERN by pulsing ISERDES bitslip, locks after MATCH_COUNT hits.
// Latency: data_o is data_i delayed by one sysclk cycle; status outputs are registered (1 cycle after decision).
// Backpressure: none, streaming; optional lock-loss monitor enabled by GLITC_INTERCOM_ALIGN_LOSS_MONITOR_EN.
module glitc_intercom_align
    import glitc_intercom_align_pkg::*;
#(
    parameter logic [3:0] TRAIN_PATTERN = TRAIN_WORD_DEFAULT,
    parameter int         SLIP_WAIT     = 8,
    parameter int         MATCH_COUNT   = 16,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic       sysclk_i,
    input  logic       rst_n_i,
    input  logic       train_i,
    input  logic [3:0] data_i,
    output logic       bitslip_o,
    output logic [3:0] data_o,
    output logic       locked_o,
    output logic       fail_o,
    output logic [3:0] slip_count_o
);

    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_LOAD  = WAIT_W'(SLIP_WAIT);
    localparam logic [SLIP_W-1:0]  SLIP_LIMIT = SLIP_W'(MAX_SLIPS);
    localparam logic [SLIP_W-1:0]  SLIP_SAT   = '1;

    align_state_t       state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [WAIT_W-1:0]  wait_q,  wait_d;
    logic [SLIP_W-1:0]  slip_q,  slip_d;
    logic               train_q;
    logic               is_match;
    logic               train_rise;

`ifdef GLITC_INTERCOM_ALIGN_LOSS_MONITOR_EN
    logic [1:0]         loss_q, loss_d;
`endif

    assign is_match     = (data_i == TRAIN_PATTERN);
    assign train_rise   = train_i & ~train_q;
    assign slip_count_o = slip_q;

    // Next-state and counter updates; train_i dropping always wins over data decisions.
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        wait_d  = wait_q;
        slip_d  = slip_q;
`ifdef GLITC_INTERCOM_ALIGN_LOSS_MONITOR_EN
        loss_d  = 2'd0;
`endif
        unique case (state_q)
            IDLE: begin
                if (train_i) begin
                    state_d = CHECK;
                    match_d = '0;
                    slip_d  = '0;
                end
            end
            CHECK: begin
                if (!train_i) begin
                    state_d = IDLE;
                end else if (is_match) begin
                    match_d = match_q + MATCH_W'(1);
                    if (match_q == MATCH_LAST) begin
                        state_d = LOCKED;
                    end
                end else if (slip_q < SLIP_LIMIT) begin
                    state_d = SLIP;
                end else begin
                    state_d = FAIL;
                end
            end
            SLIP: begin
                state_d = WAIT;
                wait_d  = WAIT_LOAD;
                slip_d  = (slip_q == SLIP_SAT) ? slip_q : slip_q + SLIP_W'(1);
            end
            WAIT: begin
                if (!train_i) begin
                    state_d = IDLE;
                end else if (wait_q <= WAIT_W'(1)) begin
                    // Settle time elapsed: restart the match run from scratch.
                    state_d = CHECK;
                    wait_d  = '0;
                    match_d = '0;
                end else begin
                    wait_d  = wait_q - WAIT_W'(1);
                end
            end
            LOCKED: begin
                if (train_rise) begin
                    state_d = CHECK;
                    match_d = '0;
                    slip_d  = '0;
                    wait_d  = '0;
                end
`ifdef GLITC_INTERCOM_ALIGN_LOSS_MONITOR_EN
                else if (train_i && !is_match) begin
                    if (loss_q == 2'd2) begin
                        // Third bad word in a row: the boundary has moved, realign.
                        state_d = CHECK;
                        match_d = '0;
                        slip_d  = '0;
                        wait_d  = '0;
                    end else begin
                        loss_d  = loss_q + 2'd1;
                    end
                end
`endif
            end
            FAIL: begin
                if (!train_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the next state
    // so they line up with the state they describe.
    always_ff @(posedge sysclk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            match_q   <= '0;
            wait_q    <= '0;
            slip_q    <= '0;
            train_q   <= 1'b0;
            data_o    <= 4'd0;
            bitslip_o <= 1'b0;
            locked_o  <= 1'b0;
            fail_o    <= 1'b0;
`ifdef GLITC_INTERCOM_ALIGN_LOSS_MONITOR_EN
            loss_q    <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            wait_q    <= wait_d;
            slip_q    <= slip_d;
            train_q   <= train_i;
            data_o    <= data_i;
            bitslip_o <= (state_d == SLIP);
            locked_o  <= (state_d == LOCKED);
            fail_o    <= (state_d == FAIL);
`ifdef GLITC_INTERCOM_ALIGN_LOSS_MONITOR_EN
            loss_q    <= loss_d;
`endif
        end
    end

endmodule
